// File: rtl/register_file_param_if.sv
// Bundles the register-file read/write ports and the handshaked dump stream.
// The master modport drives addresses, writes and dump control; the slave is the register file.
interface register_file_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic              writeSig;
    logic [WIDTH-1:0]  writeData;
    logic [WIDTH-1:0]  sourceReg;
    logic [WIDTH-1:0]  secondaryReg;
    logic              dumpReq;
    logic              dumpReady;
    logic              dumpValid;
    logic [ADDR_W-1:0] dumpIndex;
    logic [WIDTH-1:0]  dumpData;
    logic              dumpBusy;
    logic              dumpDone;

    modport master (
        output rs, rt, rd, writeSig, writeData, dumpReq, dumpReady,
        input  sourceReg, secondaryReg, dumpValid, dumpIndex, dumpData, dumpBusy, dumpDone
    );

    modport slave (
        input  rs, rt, rd, writeSig, writeData, dumpReq, dumpReady,
        output sourceReg, secondaryReg, dumpValid, dumpIndex, dumpData, dumpBusy, dumpDone
    );
endinterface

// File: rtl/register_file_param.sv
// Parametrised MIPS register file (r0 hardwired to zero) with a handshaked dump engine.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module register_file_param #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    register_file_param_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]  rf_q [DEPTH];
    logic              beat;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign rf_q[gi] = '0;
            end else begin : g_live
                logic [WIDTH-1:0] reg_q;

                always_ff @(posedge Clk or negedge Rst_n) begin
                    if (!Rst_n) begin
                        reg_q <= '0;
                    end else if (bus.writeSig && (bus.rd == ADDR_W'(gi))) begin
                        reg_q <= bus.writeData;
                    end
                end

                assign rf_q[gi] = reg_q;
            end
        end
    endgenerate

    always_comb begin
        bus.sourceReg    = rf_q[bus.rs];
        bus.secondaryReg = rf_q[bus.rt];
`ifdef REGFILE_BYPASS_EN
        // r0 is excluded so a dropped write can never leak onto a read port.
        if (bus.writeSig && (bus.rd != '0) && (bus.rd == bus.rs)) begin
            bus.sourceReg = bus.writeData;
        end
        if (bus.writeSig && (bus.rd != '0) && (bus.rd == bus.rt)) begin
            bus.secondaryReg = bus.writeData;
        end
`endif
    end

    assign beat = (state_q == SCAN) && bus.dumpReady;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.dumpReq) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (beat) begin
                    if (idx_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // The dump port reads the live array, never the bypass path.
    always_comb begin
        bus.dumpValid = (state_q == SCAN);
        bus.dumpBusy  = (state_q != IDLE);
        bus.dumpDone  = (state_q == DONE);
        bus.dumpIndex = idx_q;
        bus.dumpData  = rf_q[idx_q];
    end
endmodule
